// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards from EX/MEM and MEM/WB, muxes operands, detects load-use hazards. Latency 1 cycle.
// Backpressure: holds while out_valid & !out_ready; in_ready drops on hazard/flush/hold. ID_EX_FORWARD_EN enables forwarding.
// Without ID_EX_FORWARD_EN any in-flight producer of a used source stalls decode until it retires.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [RAW-1:0]  in_rs1_addr,
   input  logic [RAW-1:0]  in_rs2_addr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [1:0]      in_srcA_sel,
   input  logic            in_srcB_sel,
   input  logic [3:0]      in_alu_fun,
   input  logic [RAW-1:0]  in_rd_addr,
   input  logic            in_rd_we,
   input  logic            in_is_load,
   input  logic [RAW-1:0]  exm_rd_addr,
   input  logic            exm_rd_we,
   input  logic [XLEN-1:0] exm_result,
   input  logic [RAW-1:0]  wb_rd_addr,
   input  logic            wb_rd_we,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] srcA,
   output logic [XLEN-1:0] srcB,
   output logic [3:0]      alu_fun,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [RAW-1:0]  out_rd_addr,
   output logic            out_rd_we,
   output logic            out_is_load,
   output logic [XLEN-1:0] out_pc,
   output logic            hazard_stall
);

   logic            adv;
   logic            hz;
   logic            accept;
   logic            use_rs1;
   logic            use_rs2;
   logic            ld_rd;
   logic            load_use;
   logic [XLEN-1:0] rs1f;
   logic [XLEN-1:0] rs2f;
   logic [XLEN-1:0] srca_n;
   logic [XLEN-1:0] srcb_n;

   function automatic logic hit(input logic we, input logic [RAW-1:0] prod, input logic [RAW-1:0] rs);
      return we && (prod == rs) && (rs != '0);
   endfunction

   assign adv     = !out_valid | out_ready;
   assign use_rs1 = (in_srcA_sel == 2'd0);
   // rs2 is assumed live for everything except loads with an immediate operand (covers stores)
   assign use_rs2 = !in_srcB_sel | !in_is_load;

   assign ld_rd    = out_valid & out_is_load & out_rd_we;
   assign load_use = in_valid & ((use_rs1 & hit(ld_rd, out_rd_addr, in_rs1_addr)) |
                                 (use_rs2 & hit(ld_rd, out_rd_addr, in_rs2_addr)));

`ifdef ID_EX_FORWARD_EN
   always_comb begin
      rs1f = in_rs1_data;
      rs2f = in_rs2_data;
      if (hit(exm_rd_we, exm_rd_addr, in_rs1_addr))
         rs1f = exm_result;
      else if (hit(wb_rd_we, wb_rd_addr, in_rs1_addr))
         rs1f = wb_data;
      if (hit(exm_rd_we, exm_rd_addr, in_rs2_addr))
         rs2f = exm_result;
      else if (hit(wb_rd_we, wb_rd_addr, in_rs2_addr))
         rs2f = wb_data;
   end

   assign hz = load_use;
`else
   logic busy1;
   logic busy2;
   logic unused_fwd;

   assign rs1f = in_rs1_data;
   assign rs2f = in_rs2_data;

   assign busy1 = hit(out_valid & out_rd_we, out_rd_addr, in_rs1_addr) |
                  hit(exm_rd_we, exm_rd_addr, in_rs1_addr) |
                  hit(wb_rd_we, wb_rd_addr, in_rs1_addr);
   assign busy2 = hit(out_valid & out_rd_we, out_rd_addr, in_rs2_addr) |
                  hit(exm_rd_we, exm_rd_addr, in_rs2_addr) |
                  hit(wb_rd_we, wb_rd_addr, in_rs2_addr);

   assign hz = load_use | (in_valid & ((use_rs1 & busy1) | (use_rs2 & busy2)));
   assign unused_fwd = ^{exm_result, wb_data};
`endif

   always_comb begin
      srca_n = rs1f;
      case (in_srcA_sel)
         2'd0:    srca_n = rs1f;
         2'd1:    srca_n = in_pc;
         2'd2:    srca_n = in_imm;
         default: srca_n = '0;
      endcase
   end

   assign srcb_n       = in_srcB_sel ? in_imm : rs2f;
   assign accept       = in_valid & !hz & !flush;
   assign in_ready     = adv & !hz & !flush;
   assign hazard_stall = hz;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         srcA         <= '0;
         srcB         <= '0;
         alu_fun      <= 4'b0000;
         out_rs2_data <= '0;
         out_rd_addr  <= '0;
         out_rd_we    <= 1'b0;
         out_is_load  <= 1'b0;
         out_pc       <= '0;
      end else if (flush) begin
         // flush wins over a held instruction; data registers keep stale values
         out_valid <= 1'b0;
         out_rd_we <= 1'b0;
      end else if (adv) begin
         out_valid    <= accept;
         out_rd_we    <= accept & in_rd_we;
         srcA         <= srca_n;
         srcB         <= srcb_n;
         alu_fun      <= in_alu_fun;
         out_rs2_data <= rs2f;
         out_rd_addr  <= in_rd_addr;
         out_is_load  <= in_is_load;
         out_pc       <= in_pc;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal scenarios plus randomized traffic against a behavioural slot model.
// Works with or without ID_EX_FORWARD_EN defined.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [1:0]  in_srcA_sel;
   logic        in_srcB_sel, in_rd_we, in_is_load;
   logic [3:0]  in_alu_fun;
   logic [4:0]  exm_rd_addr, wb_rd_addr;
   logic        exm_rd_we, wb_rd_we;
   logic [31:0] exm_result, wb_data;
   logic        out_valid, out_ready;
   logic [31:0] srcA, srcB, out_rs2_data, out_pc;
   logic [3:0]  alu_fun;
   logic [4:0]  out_rd_addr;
   logic        out_rd_we, out_is_load, hazard_stall;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RAW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_srcA_sel(in_srcA_sel), .in_srcB_sel(in_srcB_sel), .in_alu_fun(in_alu_fun),
      .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_result(exm_result),
      .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .srcA(srcA), .srcB(srcB),
      .alu_fun(alu_fun), .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_pc(out_pc),
      .hazard_stall(hazard_stall)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp)
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      else
         pass_cnt++;
   endtask

   // ---------------- behavioural model: contents of the single stage slot ----------------
   typedef struct packed {
      logic        v;
      logic [31:0] a, b, rs2, pc;
      logic [3:0]  fun;
      logic [4:0]  rd;
      logic        we, ld;
   } slot_t;

   slot_t st = '0;
   slot_t nxt;

   function automatic logic [31:0] opnd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef ID_EX_FORWARD_EN
      if (rs != 0 && exm_rd_we && exm_rd_addr == rs) return exm_result;
      if (rs != 0 && wb_rd_we && wb_rd_addr == rs) return wb_data;
`endif
      return rf;
   endfunction

   // An incoming instruction must wait if any source it reads is still owed by a blocking producer.
   function automatic logic model_hz();
      logic       u1, u2;
      logic [4:0] prod [3];
      logic       live [3];
      u1 = (in_srcA_sel == 2'd0);
      u2 = (in_srcB_sel == 1'b0) || !in_is_load;
      prod[0] = st.rd; prod[1] = exm_rd_addr; prod[2] = wb_rd_addr;
`ifdef ID_EX_FORWARD_EN
      live[0] = st.v && st.ld && st.we; live[1] = 1'b0; live[2] = 1'b0;
`else
      live[0] = st.v && st.we; live[1] = exm_rd_we; live[2] = wb_rd_we;
`endif
      if (!in_valid) return 1'b0;
      for (int i = 0; i < 3; i++)
         if (live[i] && prod[i] != 0 &&
             ((u1 && prod[i] == in_rs1_addr) || (u2 && prod[i] == in_rs2_addr)))
            return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      logic h;
      forever begin
         @(negedge clk);
         #2;
         h = model_hz();
         chk("hazard_stall", 32'(hazard_stall), 32'(h));
         chk("in_ready", 32'(in_ready), 32'((!st.v || out_ready) && !h && !flush));
         chk("out_valid", 32'(out_valid), 32'(st.v));
         chk("out_rd_we", 32'(out_rd_we), 32'(st.we));
         if (st.v) begin
            chk("srcA", srcA, st.a);
            chk("srcB", srcB, st.b);
            chk("alu_fun", 32'(alu_fun), 32'(st.fun));
            chk("out_rs2_data", out_rs2_data, st.rs2);
            chk("out_rd_addr", 32'(out_rd_addr), 32'(st.rd));
            chk("out_is_load", 32'(out_is_load), 32'(st.ld));
            chk("out_pc", out_pc, st.pc);
         end
         nxt = st;
         if (rst) nxt = '0;
         else if (flush) begin
            nxt.v = 1'b0; nxt.we = 1'b0;
         end else if (!st.v || out_ready) begin
            if (in_valid && !h) begin
               nxt.v   = 1'b1;
               nxt.a   = (in_srcA_sel == 0) ? opnd(in_rs1_addr, in_rs1_data) :
                         (in_srcA_sel == 1) ? in_pc : (in_srcA_sel == 2) ? in_imm : 32'd0;
               nxt.rs2 = opnd(in_rs2_addr, in_rs2_data);
               nxt.b   = in_srcB_sel ? in_imm : nxt.rs2;
               nxt.pc  = in_pc;
               nxt.fun = in_alu_fun;
               nxt.rd  = in_rd_addr;
               nxt.we  = in_rd_we;
               nxt.ld  = in_is_load;
            end else begin
               nxt.v = 1'b0; nxt.we = 1'b0;
            end
         end
         @(posedge clk);
         st = nxt;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      rst = 0; flush = 0; in_valid = 0; out_ready = 1;
      in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
      in_imm = 0; in_srcA_sel = 0; in_srcB_sel = 0; in_alu_fun = 0;
      in_rd_addr = 0; in_rd_we = 0; in_is_load = 0;
      exm_rd_addr = 0; exm_rd_we = 0; exm_result = 0;
      wb_rd_addr = 0; wb_rd_we = 0; wb_data = 0;
   endtask

   task automatic set_add();
      idle();
      in_valid = 1; in_rs1_addr = 1; in_rs2_addr = 2; in_rs1_data = 5; in_rs2_data = 7;
      in_rd_addr = 3; in_rd_we = 1; in_pc = 32'h40;
   endtask

   task automatic set_load6();
      idle();
      in_valid = 1; in_is_load = 1; in_rd_addr = 6; in_rd_we = 1;
      in_rs1_data = 32'h1000; in_srcB_sel = 1; in_imm = 8;
   endtask

   task automatic set_use6();
      idle();
      in_valid = 1; in_rs2_addr = 6; in_rs2_data = 32'h33; in_rd_addr = 7; in_rd_we = 1;
   endtask

   initial begin
      idle();
      rst = 1; set_add(); rst = 1;
      @(negedge clk); set_add(); rst = 1; #1;
      chk("rst_valid", 32'(out_valid), 0); chk("rst_srcA", srcA, 0);
      chk("rst_srcB", srcB, 0); chk("rst_alu", 32'(alu_fun), 0);
      @(negedge clk); rst = 0; set_add(); #1;
      chk("rel_in_ready", 32'(in_ready), 1);
      // forward candidate: rs1=4 produced by both EX/MEM and MEM/WB
      @(negedge clk);
      idle(); in_valid = 1; in_rs1_addr = 4; in_rs1_data = 32'h11; in_srcB_sel = 1; in_imm = 32'h10;
      in_rd_addr = 8; in_rd_we = 1;
      exm_rd_addr = 4; exm_rd_we = 1; exm_result = 32'hAA;
      wb_rd_addr = 4; wb_rd_we = 1; wb_data = 32'hBB;
      #1;
      chk("add_valid", 32'(out_valid), 1); chk("add_srcA", srcA, 5);
      chk("add_srcB", srcB, 7); chk("add_alu", 32'(alu_fun), 0); chk("add_rd", 32'(out_rd_addr), 3);
`ifdef ID_EX_FORWARD_EN
      @(negedge clk);
      idle(); in_valid = 1; in_rs1_data = 32'h22; in_srcB_sel = 1;
      exm_rd_we = 1; exm_result = 32'hAA; wb_rd_we = 1; wb_data = 32'hBB; #1;
      chk("fwd_exm_srcA", srcA, 32'hAA);
`else
      chk("nofwd_stall", 32'(hazard_stall), 1); chk("nofwd_in_ready", 32'(in_ready), 0);
      @(negedge clk); exm_rd_we = 0; wb_rd_we = 0; #1;
      chk("nofwd_bubble", 32'(out_valid), 0); chk("nofwd_release", 32'(in_ready), 1);
      @(negedge clk);
      idle(); in_valid = 1; in_rs1_data = 32'h22; in_srcB_sel = 1;
      exm_rd_we = 1; exm_result = 32'hAA; wb_rd_we = 1; wb_data = 32'hBB; #1;
      chk("nofwd_srcA", srcA, 32'h11);
`endif
      @(negedge clk); set_load6(); #1;
      chk("x0_srcA", srcA, 32'h22);
      @(negedge clk); set_use6(); #1;
      chk("lu_is_load", 32'(out_is_load), 1); chk("lu_stall", 32'(hazard_stall), 1);
      chk("lu_in_ready", 32'(in_ready), 0);
      @(negedge clk); wb_rd_addr = 6; wb_rd_we = 1; wb_data = 32'h44; #1;
      chk("lu_bubble", 32'(out_valid), 0); chk("lu_bubble_we", 32'(out_rd_we), 0);
`ifdef ID_EX_FORWARD_EN
      chk("lu_clear", 32'(hazard_stall), 0);
      @(negedge clk); idle(); #1;
      chk("lu_wb_srcB", srcB, 32'h44);
`else
      chk("lu_wb_stall", 32'(hazard_stall), 1);
      @(negedge clk); wb_rd_we = 0; #1;
      chk("lu_clear", 32'(hazard_stall), 0);
      @(negedge clk); idle(); #1;
      chk("lu_rf_srcB", srcB, 32'h33);
`endif
      // back-pressure with a flush in the second held cycle
      @(negedge clk);
      idle(); in_valid = 1; in_pc = 32'h100; in_srcA_sel = 1; in_srcB_sel = 1; in_imm = 4;
      in_rd_addr = 1; in_rd_we = 1;
      @(negedge clk); out_ready = 0; in_pc = 32'h200; #1;
      chk("bp_valid", 32'(out_valid), 1); chk("bp_srcA", srcA, 32'h100); chk("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk); flush = 1; #1;
      chk("bp_hold_srcA", srcA, 32'h100); chk("fl_in_ready", 32'(in_ready), 0);
      @(negedge clk); flush = 0; #1;
      chk("fl_valid", 32'(out_valid), 0); chk("fl_rd_we", 32'(out_rd_we), 0);
      // LUI pass-through
      @(negedge clk);
      idle(); in_valid = 1; in_srcA_sel = 2; in_srcB_sel = 1; in_imm = 32'h12345000;
      in_alu_fun = 4'b1001; in_rd_addr = 5; in_rd_we = 1;
      @(negedge clk); idle(); #1;
      chk("lui_srcA", srcA, 32'h12345000); chk("lui_alu", 32'(alu_fun), 32'h9);
      // reset while stalled
      @(negedge clk); set_load6();
      @(negedge clk); set_use6(); #1;
      chk("rs_stall", 32'(hazard_stall), 1);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0; #1;
      chk("rs_valid", 32'(out_valid), 0); chk("rs_stall_clr", 32'(hazard_stall), 0);
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst         = ($urandom_range(0, 99) == 0);
         flush       = ($urandom_range(0, 19) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         in_pc       = $urandom;
         in_rs1_addr = 5'($urandom_range(0, 7));
         in_rs2_addr = 5'($urandom_range(0, 7));
         in_rs1_data = $urandom;
         in_rs2_data = $urandom;
         in_imm      = $urandom;
         in_srcA_sel = 2'($urandom_range(0, 3));
         in_srcB_sel = 1'($urandom_range(0, 1));
         in_alu_fun  = 4'($urandom_range(0, 15));
         in_rd_addr  = 5'($urandom_range(0, 7));
         in_rd_we    = 1'($urandom_range(0, 1));
         in_is_load  = ($urandom_range(0, 2) == 0);
         exm_rd_addr = 5'($urandom_range(0, 7));
         exm_rd_we   = ($urandom_range(0, 2) == 0);
         exm_result  = $urandom;
         wb_rd_addr  = 5'($urandom_range(0, 7));
         wb_rd_we    = ($urandom_range(0, 2) == 0);
         wb_data     = $urandom;
      end
      @(negedge clk); idle();
      @(negedge clk); #3;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
